// File: rtl/wide_adder_pkg.sv
// Shared types and sizing helpers for the slice-sequential wide adder.
package wide_adder_pkg;

    localparam int STATE_W   = 2;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_SLICE = 8;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int x = v - 1; x > 0; x = x >> 1) begin
            r++;
        end
        return r;
    endfunction

    // Index counter needs at least one bit even when there is a single slice.
    function automatic int idx_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/carry_select_adder_4nbit.sv
// N-bit carry-select adder built from 4-bit blocks; purely combinational.
// Each block precomputes sums for carry 0 and 1 and the incoming carry selects.
module carry_select_adder_4nbit #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    localparam int NB = N / 4;

    logic [NB:0] c;

    assign c[0] = cin;

    for (genvar g = 0; g < NB; g++) begin : g_blk
        logic [4:0] s0;
        logic [4:0] s1;
        assign s0 = {1'b0, a[4*g +: 4]} + {1'b0, b[4*g +: 4]};
        assign s1 = s0 + 5'd1;
        assign sum[4*g +: 4] = c[g] ? s1[3:0] : s0[3:0];
        assign c[g+1]        = c[g] ? s1[4]   : s0[4];
    end

    assign cout = c[NB];

endmodule

// File: rtl/wide_adder_seq_ctrl.sv
// Adds two WIDTH-bit operands by reusing one SLICE-bit adder, LSB slice first.
// Latency: out_valid rises WIDTH/SLICE edges after the operand acceptance edge.
// Backpressure: result held in DONE until out_ready; in_ready low while busy.
module wide_adder_seq_ctrl
    import wide_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SLICE = DEF_SLICE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDXW   = idx_width(NSLICE);
    localparam logic [IDXW-1:0] LAST = IDXW'(NSLICE - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [IDXW-1:0]  idx_q, idx_d;

    logic [SLICE-1:0] slice_sum;
    logic             slice_cout;
    logic [WIDTH-1:0] a_shift;
    logic [WIDTH-1:0] b_shift;
    logic [WIDTH-1:0] sum_shift;

    carry_select_adder_4nbit #(
        .N (SLICE)
    ) u_slice (
        .a    (a_q[SLICE-1:0]),
        .b    (b_q[SLICE-1:0]),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // New slice enters at the top so slice 0 lands at the bottom after NSLICE shifts.
    if (NSLICE == 1) begin : g_one
        assign a_shift   = '0;
        assign b_shift   = '0;
        assign sum_shift = slice_sum;
    end else begin : g_multi
        assign a_shift   = {{SLICE{1'b0}}, a_q[WIDTH-1:SLICE]};
        assign b_shift   = {{SLICE{1'b0}}, b_q[WIDTH-1:SLICE]};
        assign sum_shift = {slice_sum, sum_q[WIDTH-1:SLICE]};
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d   = sum_shift;
                a_d     = a_shift;
                b_d     = b_shift;
                carry_d = slice_cout;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST) begin
                    cout_d  = slice_cout;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            idx_q   <= idx_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN) || (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_wide_adder_seq_ctrl.sv
// Bench for wide_adder_seq_ctrl at 32/8 and 8/8; table vectors, corner sequences, random ops.
module tb_wide_adder_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        out_ready_i = 1'b0;
    logic        cin_i = 1'b0;
    logic [31:0] a_i = '0;
    logic [31:0] b_i = '0;

    logic        ir32, ov32, busy32, co32;
    logic [31:0] s32;
    logic        ir8, ov8, busy8, co8;
    logic [7:0]  s8;

    logic        m_ir, m_ov, m_busy, m_co;
    logic [31:0] m_sum;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wide_adder_seq_ctrl #(.WIDTH(32), .SLICE(8)) dut32 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid_i & ~sel),
        .in_ready  (ir32),
        .a         (a_i),
        .b         (b_i),
        .cin       (cin_i),
        .out_valid (ov32),
        .out_ready (out_ready_i & ~sel),
        .sum       (s32),
        .cout      (co32),
        .busy      (busy32)
    );

    wide_adder_seq_ctrl #(.WIDTH(8), .SLICE(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid_i & sel),
        .in_ready  (ir8),
        .a         (a_i[7:0]),
        .b         (b_i[7:0]),
        .cin       (cin_i),
        .out_valid (ov8),
        .out_ready (out_ready_i & sel),
        .sum       (s8),
        .cout      (co8),
        .busy      (busy8)
    );

    assign m_ir   = sel ? ir8   : ir32;
    assign m_ov   = sel ? ov8   : ov32;
    assign m_busy = sel ? busy8 : busy32;
    assign m_co   = sel ? co8   : co32;
    assign m_sum  = sel ? {24'b0, s8} : s32;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] s;
        logic        co;
    } vec_t;

    vec_t vt[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: plain unsigned addition, width-limited; returns {cout, sum}.
    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic c, input int w);
        logic [32:0] full;
        full = {1'b0, a} + {1'b0, b} + {32'b0, c};
        if (w == 8) return {full[8], 24'b0, full[7:0]};
        return full;
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic c,
                          input int stall, input logic [31:0] es, input logic ec,
                          input string nm);
        int n;
        int lat;
        int nsl;
        nsl = sel ? 1 : 4;
        n = 0;
        while (!m_ir && n < 50) begin
            tick();
            n++;
        end
        chk({nm, "_in_ready_wait"}, m_ir, 1);
        a_i = a;
        b_i = b;
        cin_i = c;
        in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        lat = 0;
        while (!m_ov && lat < 40) begin
            chk({nm, "_busy_run"}, m_busy, 1);
            chk({nm, "_in_ready_run"}, m_ir, 0);
            tick();
            lat++;
        end
        chk({nm, "_latency"}, lat, nsl);
        chk({nm, "_sum"}, m_sum, es);
        chk({nm, "_cout"}, m_co, ec);
        chk({nm, "_busy_done"}, m_busy, 1);
        chk({nm, "_in_ready_done"}, m_ir, 0);
        for (int i = 0; i < stall; i++) begin
            tick();
            chk({nm, "_hold_valid"}, m_ov, 1);
            chk({nm, "_hold_sum"}, {m_co, m_sum}, {ec, es});
        end
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        chk({nm, "_valid_drop"}, m_ov, 0);
        chk({nm, "_in_ready_back"}, m_ir, 1);
    endtask

    initial begin
        logic [32:0] exp;
        logic [31:0] ra, rb;
        logic        rc;
        int          seen;

        vt[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1};
        vt[1] = '{32'h12345678, 32'h0F0F0F0F, 1'b1, 32'h21436588, 1'b0};
        vt[2] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1};
        vt[3] = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0};
        vt[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1};
        vt[5] = '{32'h00FF00FF, 32'h00010001, 1'b0, 32'h01000100, 1'b0};
        vt[6] = '{32'h0000FFFF, 32'h0000FFFF, 1'b0, 32'h0001FFFE, 1'b0};

        #1;
        chk("reset_in_ready", {ir32, ir8}, 2'b11);
        chk("reset_out_valid", {ov32, ov8}, 2'b00);
        chk("reset_busy", {busy32, busy8}, 2'b00);
        chk("reset_sum", {s32, s8}, 40'h0);
        chk("reset_cout", {co32, co8}, 2'b00);
        tick();
        tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) begin
            run_op(vt[i].a, vt[i].b, vt[i].cin, i % 3, vt[i].s, vt[i].co, $sformatf("vec%0d", i));
        end

        // Backpressure with in_valid pulses ignored while the result is held.
        a_i = 32'h80000000;
        b_i = 32'h80000000;
        cin_i = 1'b0;
        in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        repeat (4) tick();
        chk("bp_valid_rise", ov32, 1);
        a_i = 32'h11111111;
        b_i = 32'h22222222;
        for (int i = 0; i < 10; i++) begin
            in_valid_i = i[0];
            tick();
            chk("bp_hold", {ov32, co32, s32, ir32, busy32}, {1'b1, 1'b1, 32'h0, 1'b0, 1'b1});
        end
        in_valid_i = 1'b0;
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        chk("bp_release", {ov32, ir32}, 2'b01);
        tick();
        chk("bp_stay_idle", {busy32, ir32}, 2'b01);

        // Reset after two RUN edges discards the partial result.
        a_i = 32'hAAAAAAAA;
        b_i = 32'h55555555;
        in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        tick();
        tick();
        chk("rst_mid_busy_before", busy32, 1);
        rst = 1'b1;
        #1;
        chk("rst_mid_outputs", {ir32, ov32, busy32, co32, s32}, {1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
        tick();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ov32 || busy32) seen++;
        end
        chk("rst_mid_no_valid", seen, 0);
        run_op(32'd3, 32'd4, 1'b0, 0, 32'd7, 1'b0, "post_rst");

        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            tick();
            for (int i = 0; i < 1000; i++) begin
                ra = $urandom();
                rb = $urandom();
                rc = 1'($urandom_range(0, 1));
                if (sel) begin
                    ra = ra & 32'hFF;
                    rb = rb & 32'hFF;
                end
                exp = model(ra, rb, rc, sel ? 8 : 32);
                run_op(ra, rb, rc, $urandom_range(0, 3), exp[31:0], exp[32],
                       sel ? "rnd8" : "rnd32");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
